// File: rtl/event_scheduler_pkg.sv
// Shared constants for the event scheduler: default task durations in clock cycles.
`timescale 1ns/1ps
package event_scheduler_pkg;

    localparam int T1_CYCLES_DEFAULT = 3;
    localparam int T2_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/event_pulse_timer.sv
// Samples one event input, detects a rising or falling edge, and produces a
// fixed-length registered pulse that is reloaded by every new edge.
`timescale 1ns/1ps
module event_pulse_timer #(
    parameter int CYCLES    = 3,
    parameter bit FALL_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic event_i,
    output logic sample_o,
    output logic active_o
);

    localparam int CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sample_q;
    logic             delay_q;
    logic             trig;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             active_q;

    // sample_q/delay_q form a two-stage history; the edge is judged between them.
    always_comb begin
        trig = 1'b0;
        if (FALL_EDGE) begin
            trig = ~sample_q & delay_q;
        end else begin
            trig = sample_q & ~delay_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (trig) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q <= 1'b0;
            delay_q  <= 1'b0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sample_q <= event_i;
            delay_q  <= sample_q;
            cnt_q    <= cnt_d;
            active_q <= (cnt_d != '0);
        end
    end

    assign sample_o = sample_q;
    assign active_o = active_q;

endmodule

// File: rtl/event_scheduler.sv
// Turns two event inputs into three clock-aligned task strobes: a timed pulse on
// event_a rise, a timed pulse on event_b fall, and a level while both are high.
`timescale 1ns/1ps
module event_scheduler
    import event_scheduler_pkg::*;
#(
    parameter int T1_CYCLES = T1_CYCLES_DEFAULT,
    parameter int T2_CYCLES = T2_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic event_a,
    input  logic event_b,
    output logic task_1_active,
    output logic task_2_active,
    output logic task_3_active
);

    logic a_s;
    logic b_s;
    logic task_3_q;

    event_pulse_timer #(
        .CYCLES    (T1_CYCLES),
        .FALL_EDGE (1'b0)
    ) u_task_1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .event_i  (event_a),
        .sample_o (a_s),
        .active_o (task_1_active)
    );

    event_pulse_timer #(
        .CYCLES    (T2_CYCLES),
        .FALL_EDGE (1'b1)
    ) u_task_2 (
        .clk_i    (clk),
        .rst_i    (rst),
        .event_i  (event_b),
        .sample_o (b_s),
        .active_o (task_2_active)
    );

    // Built from the sampled copies, so it lags the raw inputs by two edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            task_3_q <= 1'b0;
        end else begin
            task_3_q <= a_s & b_s;
        end
    end

    assign task_3_active = task_3_q;

endmodule

// File: tb/tb_event_scheduler.sv
// Directed timeline bench for event_scheduler with hand-derived expected strobes.
`timescale 1ns/1ps
module tb_event_scheduler;

    logic clk;
    logic rst;
    logic event_a;
    logic event_b;
    logic task_1_active;
    logic task_2_active;
    logic task_3_active;

    int checks;
    int errors;

    event_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .event_a       (event_a),
        .event_b       (event_b),
        .task_1_active (task_1_active),
        .task_2_active (task_2_active),
        .task_3_active (task_3_active)
    );

    // clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic chk3(input logic e1, input logic e2, input logic e3);
        check_bit("task_1", task_1_active, e1);
        check_bit("task_2", task_2_active, e2);
        check_bit("task_3", task_3_active, e3);
    endtask

    task automatic at_time(input int t);
        if ($time < t) #(t - $time);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        event_a = 1'b0;
        event_b = 1'b0;

        // reset held across an edge while events toggle
        at_time(2);   event_a = 1'b1; event_b = 1'b1;
        at_time(6);   chk3(1'b0, 1'b0, 1'b0);
        at_time(8);   event_a = 1'b0; event_b = 1'b0;
        at_time(10);  rst = 1'b0;

        // single event_a pulse: task_1 high after edges 35, 45, 55
        at_time(20);  event_a = 1'b1;
        at_time(26);  chk3(1'b0, 1'b0, 1'b0);
        at_time(36);  chk3(1'b1, 1'b0, 1'b0);
        at_time(40);  event_a = 1'b0;
        at_time(46);  chk3(1'b1, 1'b0, 1'b0);
        at_time(50);  event_b = 1'b1;
        at_time(56);  chk3(1'b1, 1'b0, 1'b0);
        at_time(66);  chk3(1'b0, 1'b0, 1'b0);

        // event_b fall at 70: task_2 high after 85, 95, 105
        at_time(70);  event_b = 1'b0;
        at_time(76);  chk3(1'b0, 1'b0, 1'b0);
        at_time(80);  event_a = 1'b1; event_b = 1'b1;
        at_time(86);  chk3(1'b0, 1'b1, 1'b0);
        at_time(96);  chk3(1'b1, 1'b1, 1'b1);
        at_time(100); event_a = 1'b0; event_b = 1'b0;
        at_time(106); chk3(1'b1, 1'b1, 1'b1);
        // task_2 reloaded at 115 by the fall at 100
        at_time(116); chk3(1'b1, 1'b1, 1'b0);
        at_time(126); chk3(1'b0, 1'b1, 1'b0);
        at_time(136); chk3(1'b0, 1'b1, 1'b0);
        at_time(146); chk3(1'b0, 1'b0, 1'b0);

        // retrigger: rise at 150 loads at 165, rise at 180 reloads at 195
        at_time(150); event_a = 1'b1;
        at_time(156); check_bit("retrig_pre", task_1_active, 1'b0);
        at_time(170); event_a = 1'b0;
        at_time(180); event_a = 1'b1;
        for (int t = 166; t <= 216; t += 10) begin
            at_time(t);
            check_bit("retrig_hold", task_1_active, 1'b1);
        end
        at_time(226); check_bit("retrig_end", task_1_active, 1'b0);

        // simultaneous a rise / b fall, then async reset mid-pulse
        at_time(228); event_a = 1'b0; event_b = 1'b0;
        at_time(230); event_b = 1'b1;
        at_time(240); event_a = 1'b1; event_b = 1'b0;
        at_time(256); chk3(1'b1, 1'b1, 1'b0);
        at_time(258); rst = 1'b1;
        at_time(259); chk3(1'b0, 1'b0, 1'b0);
        at_time(266); chk3(1'b0, 1'b0, 1'b0);

        // release with event_a held high: counts as a rise, pulse after 295..315
        at_time(280); rst = 1'b0;
        at_time(286); chk3(1'b0, 1'b0, 1'b0);
        at_time(296); chk3(1'b1, 1'b0, 1'b0);
        at_time(306); chk3(1'b1, 1'b0, 1'b0);
        at_time(316); chk3(1'b1, 1'b0, 1'b0);
        at_time(326); chk3(1'b0, 1'b0, 1'b0);

        // release with event_b held high: never a fall
        at_time(330); rst = 1'b1; event_a = 1'b0; event_b = 1'b1;
        at_time(340); rst = 1'b0;
        for (int t = 346; t <= 386; t += 10) begin
            at_time(t);
            chk3(1'b0, 1'b0, 1'b0);
        end

        at_time(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
